eight_bit_computer: RTL and testbench
=====================================

Name: eight_bit_computer

Overview:
- Top level of the 8-bit bus-based computer; currently holds general-purpose register 1 (reg1) attached to a shared 8-bit tri-state system bus.
- External control signals (from a future control unit or a bench) load reg1 from the bus, drive reg1 onto the bus, or clear it.
- Later blocks (further registers, ALU, memory, control unit) attach to the same bus using the same load/out/clear convention.

Parameters:
- WIDTH, 8, data width of the bus and of reg1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- bus  inout  WIDTH  shared tri-state system bus.
- reg1_data_in  input  1  load enable: capture bus into reg1 on the next rising clk.
- reg1_data_out  input  1  output enable: drive reg1 onto bus while high.
- reg1_clr  input  1  synchronous clear of reg1.
- reg1_value  output  WIDTH  reg1 contents, always driven, for debug and observation.

Behaviour:
- Reset: reset low clears reg1 to 0 immediately, independent of clk. While reset is low, reg1 stays at 0 and the bus is not driven (high-Z), regardless of reg1_data_out.
- Priority on each rising clk edge, with reset high:
  - reg1_clr=1 sets reg1 to 0.
  - Otherwise, reg1_data_in=1 sets reg1 to the current value on bus.
  - Otherwise, reg1 holds its value.
- Load latency: one edge. The value on bus just before the rising edge appears in reg1 and on reg1_value right after that edge.
- Bus drive:
  - Combinational. bus = reg1 while reg1_data_out=1 and reset=1; otherwise every bus bit is high-Z.
  - No clock latency: the enable takes effect in the same delta.
- The block never drives the bus unless reg1_data_out=1. Only one driver may be enabled at a time; bus contention is the responsibility of the controller.
- Simultaneous reg1_data_out=1 and reg1_data_in=1: reg1 reloads its own value and is unchanged.
- Simultaneous reg1_clr=1 and reg1_data_out=1: bus shows the old value until the edge, then 0 after it.
- Load with a floating bus (no driver): reg1 captures whatever value is on the bus (X/Z in simulation). Controllers must not do this.
- reg1_value = reg1 at all times, including during reset (0).
- No other internal state. Control inputs are sampled only at the rising clk edge; reg1_data_out is the only combinational path.

Test Plan:
- Reset: drive reset=0 with reg1 holding 0xCD → reg1_value=0x00 immediately without a clock edge; bus is Z even with reg1_data_out=1.
- Load: bench drives bus=0xCD, reg1_data_in=1, one rising clk → reg1_value=0xCD. Then reg1_data_in=0, bench releases bus, reg1_data_out=1 → bus reads 0xCD.
- Tri-state release: after the previous step, reg1_data_out=0 → bus reads 0xZZ and reg1_value stays 0xCD.
- Hold: bus=0x5A with reg1_data_in=0 over 3 clocks → reg1_value stays 0xCD.
- Clear priority: bus=0x3C with reg1_data_in=1 and reg1_clr=1, one clock → reg1_value=0x00.
- Self-reload: reg1=0x81, reg1_data_out=1 and reg1_data_in=1, one clock → reg1 stays 0x81 and bus stays 0x81.

Source files
------------

// File: rtl/eight_bit_computer.sv
// -----------------------------------------------------------------------------
// eight_bit_computer
//
// Top level of the 8-bit bus-based computer. It currently contains
// general-purpose register 1 (reg1), attached to a shared tri-state system bus.
// Further registers, the ALU, memory and the control unit will attach to the
// same bus later and use the same load / out / clear control convention.
//
// Ports
//   clk            in     1      system clock; all state changes on rising edge
//   reset          in     1      asynchronous, active-low reset
//   bus            inout  WIDTH  shared tri-state system bus
//   reg1_data_in   in     1      load enable: capture bus into reg1 at next edge
//   reg1_data_out  in     1      output enable: drive reg1 onto bus while high
//   reg1_clr       in     1      synchronous clear of reg1 (wins over load)
//   reg1_value     out    WIDTH  reg1 contents, always driven (debug/observe)
// -----------------------------------------------------------------------------
module eight_bit_computer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             reg1_data_in,
    input  logic             reg1_data_out,
    input  logic             reg1_clr,
    output logic [WIDTH-1:0] reg1_value
);

    logic [WIDTH-1:0] reg1_q;
    logic [WIDTH-1:0] reg1_d;
    logic             bus_drive_en;

    // Next-state: clear has priority over load; otherwise hold.
    // When reg1 is both driving and loading the bus it reloads its own value.
    always_comb begin
        reg1_d = reg1_q;
        if (reg1_clr) begin
            reg1_d = '0;
        end else if (reg1_data_in) begin
            reg1_d = bus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg1_q <= '0;
        end else begin
            reg1_q <= reg1_d;
        end
    end

    // The output enable is purely combinational; reset also forces release
    // so that nothing fights other drivers while the system is held in reset.
    assign bus_drive_en = reg1_data_out & reset;
    assign bus          = bus_drive_en ? reg1_q : {WIDTH{1'bz}};

    assign reg1_value = reg1_q;

endmodule

// File: tb/tb_eight_bit_computer.sv
// -----------------------------------------------------------------------------
// Self-checking testbench for eight_bit_computer.
// The bus carries weak pull-ups so that a released (high-Z) bus reads as all
// ones; a released bus is therefore checked against 8'hFF with reg1 holding a
// different value, which distinguishes "released" from "driving reg1".
// -----------------------------------------------------------------------------
module tb_eight_bit_computer;

    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] BUS_RELEASED = 8'hFF;

    logic             clk;
    logic             reset;
    wire  [WIDTH-1:0] bus;
    logic             reg1_data_in;
    logic             reg1_data_out;
    logic             reg1_clr;
    logic [WIDTH-1:0] reg1_value;

    logic             tb_drive_en;
    logic [WIDTH-1:0] tb_drive_val;

    int n_checks;
    int n_fail;

    assign bus = tb_drive_en ? tb_drive_val : {WIDTH{1'bz}};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pull
            pullup (bus[gi]);
        end
    endgenerate

    eight_bit_computer #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .reg1_data_in  (reg1_data_in),
        .reg1_data_out (reg1_data_out),
        .reg1_clr      (reg1_clr),
        .reg1_value    (reg1_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; return 1 time unit after it so that
    // subsequent drives and samples are away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_controls();
        reg1_data_in  = 1'b0;
        reg1_data_out = 1'b0;
        reg1_clr      = 1'b0;
        tb_drive_en   = 1'b0;
        tb_drive_val  = '0;
    endtask

    task automatic load_value(input logic [WIDTH-1:0] v);
        tb_drive_en  = 1'b1;
        tb_drive_val = v;
        reg1_data_in = 1'b1;
        tick();
        reg1_data_in = 1'b0;
        tb_drive_en  = 1'b0;
    endtask

    task automatic test_reset_state();
        // reset has been low since time 0
        #3;
        n_checks++;
        if (reg1_value !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: reg1_value got %h expected %h", reg1_value, 8'h00);
        end
        reg1_data_out = 1'b1;
        #1;
        n_checks++;
        if (bus !== BUS_RELEASED) begin
            n_fail++;
            $display("FAIL reset_state_bus: bus got %h expected %h", bus, BUS_RELEASED);
        end
        reg1_data_out = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        $display("reset_state: reg1_value=%h", reg1_value);
    endtask

    task automatic test_load();
        load_value(8'hCD);
        n_checks++;
        if (reg1_value !== 8'hCD) begin
            n_fail++;
            $display("FAIL load: reg1_value got %h expected %h", reg1_value, 8'hCD);
        end
        reg1_data_out = 1'b1;
        #1;
        n_checks++;
        if (bus !== 8'hCD) begin
            n_fail++;
            $display("FAIL load_drive: bus got %h expected %h", bus, 8'hCD);
        end
        $display("load: reg1_value=%h bus=%h", reg1_value, bus);
    endtask

    task automatic test_release();
        reg1_data_out = 1'b0;
        #1;
        n_checks++;
        if (bus !== BUS_RELEASED) begin
            n_fail++;
            $display("FAIL release_bus: bus got %h expected %h", bus, BUS_RELEASED);
        end
        n_checks++;
        if (reg1_value !== 8'hCD) begin
            n_fail++;
            $display("FAIL release_value: reg1_value got %h expected %h", reg1_value, 8'hCD);
        end
        $display("release: bus=%h reg1_value=%h", bus, reg1_value);
    endtask

    task automatic test_hold();
        tb_drive_en  = 1'b1;
        tb_drive_val = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (reg1_value !== 8'hCD) begin
                n_fail++;
                $display("FAIL hold_%0d: reg1_value got %h expected %h", i, reg1_value, 8'hCD);
            end
        end
        tb_drive_en = 1'b0;
        $display("hold: reg1_value=%h after 3 clocks with bus=5A", reg1_value);
    endtask

    task automatic test_clear_priority();
        tb_drive_en  = 1'b1;
        tb_drive_val = 8'h3C;
        reg1_data_in = 1'b1;
        reg1_clr     = 1'b1;
        tick();
        idle_controls();
        n_checks++;
        if (reg1_value !== 8'h00) begin
            n_fail++;
            $display("FAIL clear_priority: reg1_value got %h expected %h", reg1_value, 8'h00);
        end
        $display("clear_priority: reg1_value=%h", reg1_value);
    endtask

    task automatic test_self_reload();
        load_value(8'h81);
        reg1_data_out = 1'b1;
        reg1_data_in  = 1'b1;
        tick();
        n_checks++;
        if (reg1_value !== 8'h81) begin
            n_fail++;
            $display("FAIL self_reload_value: reg1_value got %h expected %h", reg1_value, 8'h81);
        end
        n_checks++;
        if (bus !== 8'h81) begin
            n_fail++;
            $display("FAIL self_reload_bus: bus got %h expected %h", bus, 8'h81);
        end
        idle_controls();
        $display("self_reload: reg1_value=%h", reg1_value);
    endtask

    task automatic test_clear_while_out();
        load_value(8'h42);
        reg1_data_out = 1'b1;
        reg1_clr      = 1'b1;
        #1;
        n_checks++;
        if (bus !== 8'h42) begin
            n_fail++;
            $display("FAIL clr_out_before: bus got %h expected %h", bus, 8'h42);
        end
        tick();
        n_checks++;
        if (bus !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_out_after: bus got %h expected %h", bus, 8'h00);
        end
        idle_controls();
        $display("clear_while_out: reg1_value=%h", reg1_value);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 8'h01; vals[1] = 8'hA5; vals[2] = 8'h7E; vals[3] = 8'hFE;
        tb_drive_en  = 1'b1;
        reg1_data_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tb_drive_val = vals[i];
            tick();
            n_checks++;
            if (reg1_value !== vals[i]) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: reg1_value got %h expected %h", i, reg1_value, vals[i]);
            end
            $display("back_to_back: load %h -> reg1_value=%h", vals[i], reg1_value);
        end
        idle_controls();
    endtask

    task automatic test_async_reset();
        load_value(8'hCD);
        @(negedge clk);
        #2;
        reg1_data_out = 1'b1;
        reset         = 1'b0;
        #1;
        n_checks++;
        if (reg1_value !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: reg1_value got %h expected %h", reg1_value, 8'h00);
        end
        n_checks++;
        if (bus !== BUS_RELEASED) begin
            n_fail++;
            $display("FAIL async_reset_bus: bus got %h expected %h", bus, BUS_RELEASED);
        end
        $display("async_reset: reg1_value=%h bus=%h", reg1_value, bus);
        @(negedge clk);
        reset = 1'b1;
        reg1_data_out = 1'b0;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        idle_controls();

        test_reset_state();
        test_load();
        test_release();
        test_hold();
        test_clear_priority();
        test_self_reload();
        test_clear_while_out();
        test_back_to_back();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
